// File: rtl/ble_pkg.sv
// Shared types and defaults for the multi-channel BLE motor controller.
//   ch_state_e : per-channel FSM state encoding (3 bits)
//   RETRY_W    : width of the per-channel auto-retry counter
//   DEF_*      : production timing defaults (100 MHz system clock)
//   cw()       : counter width for a terminal count, never narrower than 1 bit
package ble_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_DEADTIME = 3'd2,
    ST_ALARM    = 3'd3,
    ST_ARESET   = 3'd4,
    ST_LOCKOUT  = 3'd5
  } ch_state_e;

  localparam int RETRY_W             = 2;
  localparam int DEF_DEADTIME_CYC    = 1_000_000;
  localparam int DEF_ALARM_HOLD_CYC  = 1_000_000_000;
  localparam int DEF_RESET_PULSE_CYC = 1_000_000;
  localparam int DEF_MAX_RETRY       = 3;
  localparam int DEF_SPD_WIN_CYC     = 100_000_000;
  localparam int DEF_SPD_W           = 16;

  function automatic int cw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ble_ch_ctrl.sv
// One motor channel: alarm/speed synchronisers, control FSM with dead-time,
// alarm-hold, reset-pulse timers, retry counting and speed edge counting.
// Ports:
//   sys_clk, sys_rst      clock, async active-low reset
//   motor_state           run request
//   motor_direction       1 = forward, 0 = reverse
//   motor_alarm_reset     manual alarm reset (level)
//   speed_sel             {m1,m0}
//   speed_out, alarm_out_n  raw async driver feedback
//   win_end               shared speed window terminal cycle
//   fwd/rev/stop_mode/alarm_reset/m0/m1  registered driver controls
//   ch_locked, ch_alarm   registered status
//   retry_cnt             auto-retry count
//   speed_cnt             rising edges in the last completed window
module ble_ch_ctrl import ble_pkg::*; #(
  parameter int DEADTIME_CYC    = DEF_DEADTIME_CYC,
  parameter int ALARM_HOLD_CYC  = DEF_ALARM_HOLD_CYC,
  parameter int RESET_PULSE_CYC = DEF_RESET_PULSE_CYC,
  parameter int MAX_RETRY       = DEF_MAX_RETRY,
  parameter int SPD_W           = DEF_SPD_W
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               motor_state,
  input  logic               motor_direction,
  input  logic               motor_alarm_reset,
  input  logic [1:0]         speed_sel,
  input  logic               speed_out,
  input  logic               alarm_out_n,
  input  logic               win_end,
  output logic               fwd,
  output logic               rev,
  output logic               stop_mode,
  output logic               alarm_reset,
  output logic               m0,
  output logic               m1,
  output logic               ch_locked,
  output logic               ch_alarm,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [SPD_W-1:0]   speed_cnt
);

  localparam int DT_W = cw(DEADTIME_CYC);
  localparam int AH_W = cw(ALARM_HOLD_CYC);
  localparam int RP_W = cw(RESET_PULSE_CYC);

  // Down-counters load N-1 and leave on zero, so the state lasts exactly N cycles.
  localparam logic [DT_W-1:0]    DT_LOAD = DT_W'(DEADTIME_CYC - 1);
  localparam logic [RP_W-1:0]    RP_LOAD = RP_W'(RESET_PULSE_CYC - 1);
  localparam logic [AH_W-1:0]    AH_LAST = AH_W'(ALARM_HOLD_CYC - 1);
  localparam logic [RETRY_W-1:0] MAX_R   = RETRY_W'(MAX_RETRY);

  // Synchronisers: alarm presets inactive (high), speed presets low.
  logic al_s1, al_s2, sp_s1, sp_s2, sp_d;
  logic alarm, rise;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      al_s1 <= 1'b1;
      al_s2 <= 1'b1;
      sp_s1 <= 1'b0;
      sp_s2 <= 1'b0;
      sp_d  <= 1'b0;
    end else begin
      al_s1 <= alarm_out_n;
      al_s2 <= al_s1;
      sp_s1 <= speed_out;
      sp_s2 <= sp_s1;
      sp_d  <= sp_s2;
    end
  end

  assign alarm = ~al_s2;
  assign rise  = sp_s2 & ~sp_d;

  // Control FSM
  ch_state_e       st;
  logic            dir;
  logic [DT_W-1:0] dt_tmr;
  logic [AH_W-1:0] ah_tmr;
  logic [RP_W-1:0] rp_tmr;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      st        <= ST_IDLE;
      dir       <= 1'b0;
      dt_tmr    <= '0;
      ah_tmr    <= '0;
      rp_tmr    <= '0;
      retry_cnt <= '0;
    end else if (motor_alarm_reset) begin
      // Manual reset beats everything; holding it keeps reloading the pulse.
      st        <= ST_ARESET;
      rp_tmr    <= RP_LOAD;
      retry_cnt <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (alarm) begin
            st     <= ST_ALARM;
            ah_tmr <= '0;
          end else if (motor_state) begin
            st  <= ST_RUN;
            dir <= motor_direction;
          end
        end
        ST_RUN: begin
          if (alarm) begin
            st     <= ST_ALARM;
            ah_tmr <= '0;
          end else if (!motor_state) begin
            st <= ST_IDLE;
          end else if (motor_direction != dir) begin
            st     <= ST_DEADTIME;
            dir    <= motor_direction;
            dt_tmr <= DT_LOAD;
          end
        end
        ST_DEADTIME: begin
          if (alarm) begin
            st     <= ST_ALARM;
            ah_tmr <= '0;
          end else if (!motor_state) begin
            st <= ST_IDLE;
          end else begin
            // Track late direction changes without restarting the dead-time.
            dir <= motor_direction;
            if (dt_tmr == '0) st <= ST_RUN;
            else              dt_tmr <= dt_tmr - 1'b1;
          end
        end
        ST_ALARM: begin
          if (!alarm) begin
            st     <= ST_IDLE;
            ah_tmr <= '0;
          end else if (ah_tmr == AH_LAST) begin
            if (retry_cnt < MAX_R) begin
              st        <= ST_ARESET;
              retry_cnt <= retry_cnt + 1'b1;
              rp_tmr    <= RP_LOAD;
            end else begin
              st <= ST_LOCKOUT;
            end
          end else begin
            ah_tmr <= ah_tmr + 1'b1;
          end
        end
        ST_ARESET: begin
          // A still-active alarm is picked up again from IDLE.
          if (rp_tmr == '0) st <= ST_IDLE;
          else              rp_tmr <= rp_tmr - 1'b1;
        end
        ST_LOCKOUT: st <= ST_LOCKOUT;
        default:    st <= ST_IDLE;
      endcase
    end
  end

  // Registered outputs decoded from the current state (one cycle behind it).
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      fwd         <= 1'b0;
      rev         <= 1'b0;
      stop_mode   <= 1'b0;
      alarm_reset <= 1'b0;
      ch_alarm    <= 1'b0;
      ch_locked   <= 1'b0;
      m0          <= 1'b0;
      m1          <= 1'b0;
    end else begin
      fwd         <= (st == ST_RUN) &  dir;
      rev         <= (st == ST_RUN) & ~dir;
      stop_mode   <= (st == ST_ARESET);
      alarm_reset <= (st == ST_ARESET);
      ch_alarm    <= (st == ST_ALARM);
      ch_locked   <= (st == ST_LOCKOUT);
      {m1, m0}    <= speed_sel;
    end
  end

  // Speed edge counter; an edge on the window-end cycle lands in that window.
  logic [SPD_W-1:0] edge_cnt, edge_nxt;

  assign edge_nxt = (rise && edge_cnt != '1) ? edge_cnt + 1'b1 : edge_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      edge_cnt  <= '0;
      speed_cnt <= '0;
    end else if (win_end) begin
      speed_cnt <= edge_nxt;
      edge_cnt  <= '0;
    end else begin
      edge_cnt <= edge_nxt;
    end
  end

endmodule

// File: rtl/ble_motor_ctrl.sv
// Multi-channel BLE motor-driver controller: shared speed window counter and
// one ble_ch_ctrl per channel.
// Ports: sys_clk, sys_rst (async active-low); per-channel command inputs
// motor_state/motor_direction/motor_alarm_reset/speed_sel; raw driver
// feedback speed_out/alarm_out_n; registered driver controls fwd/rev/
// stop_mode/alarm_reset/m0/m1; status ch_locked/ch_alarm/retry_cnt/speed_cnt.
module ble_motor_ctrl import ble_pkg::*; #(
  parameter int N_CH            = 2,
  parameter int DEADTIME_CYC    = DEF_DEADTIME_CYC,
  parameter int ALARM_HOLD_CYC  = DEF_ALARM_HOLD_CYC,
  parameter int RESET_PULSE_CYC = DEF_RESET_PULSE_CYC,
  parameter int MAX_RETRY       = DEF_MAX_RETRY,
  parameter int SPD_WIN_CYC     = DEF_SPD_WIN_CYC,
  parameter int SPD_W           = DEF_SPD_W
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst,
  input  logic [N_CH-1:0]                motor_state,
  input  logic [N_CH-1:0]                motor_direction,
  input  logic [N_CH-1:0]                motor_alarm_reset,
  input  logic [N_CH-1:0][1:0]           speed_sel,
  input  logic [N_CH-1:0]                speed_out,
  input  logic [N_CH-1:0]                alarm_out_n,
  output logic [N_CH-1:0]                fwd,
  output logic [N_CH-1:0]                rev,
  output logic [N_CH-1:0]                stop_mode,
  output logic [N_CH-1:0]                alarm_reset,
  output logic [N_CH-1:0]                m0,
  output logic [N_CH-1:0]                m1,
  output logic [N_CH-1:0]                ch_locked,
  output logic [N_CH-1:0]                ch_alarm,
  output logic [N_CH-1:0][RETRY_W-1:0]   retry_cnt,
  output logic [N_CH-1:0][SPD_W-1:0]     speed_cnt
);

  localparam int WIN_W = cw(SPD_WIN_CYC);

  // Free-running window shared by all channels so their speeds are coherent.
  logic [WIN_W-1:0] win_cnt;
  logic             win_end;

  assign win_end = (win_cnt == WIN_W'(SPD_WIN_CYC - 1));

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) win_cnt <= '0;
    else          win_cnt <= win_end ? '0 : win_cnt + 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ble_ch_ctrl #(
      .DEADTIME_CYC    (DEADTIME_CYC),
      .ALARM_HOLD_CYC  (ALARM_HOLD_CYC),
      .RESET_PULSE_CYC (RESET_PULSE_CYC),
      .MAX_RETRY       (MAX_RETRY),
      .SPD_W           (SPD_W)
    ) u_ch (
      .sys_clk           (sys_clk),
      .sys_rst           (sys_rst),
      .motor_state       (motor_state[i]),
      .motor_direction   (motor_direction[i]),
      .motor_alarm_reset (motor_alarm_reset[i]),
      .speed_sel         (speed_sel[i]),
      .speed_out         (speed_out[i]),
      .alarm_out_n       (alarm_out_n[i]),
      .win_end           (win_end),
      .fwd               (fwd[i]),
      .rev               (rev[i]),
      .stop_mode         (stop_mode[i]),
      .alarm_reset       (alarm_reset[i]),
      .m0                (m0[i]),
      .m1                (m1[i]),
      .ch_locked         (ch_locked[i]),
      .ch_alarm          (ch_alarm[i]),
      .retry_cnt         (retry_cnt[i]),
      .speed_cnt         (speed_cnt[i])
    );
  end

endmodule

// File: tb/tb_ble_motor_ctrl.sv
// Directed bench for ble_motor_ctrl with small timing parameters. Expected
// values are queued when stimulus is applied and popped when the DUT output
// is sampled (#1 after the active edge).
module tb_ble_motor_ctrl;
  import ble_pkg::*;

  localparam int N_CH  = 2;
  localparam int SPD_W = 16;
  localparam int WIN   = 50;

  // Channel-0 status code bits
  localparam logic [31:0] C_FWD = 1, C_REV = 2, C_ARST = 12, C_ALM = 16, C_LCK = 32;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  logic [N_CH-1:0]              motor_state, motor_direction, motor_alarm_reset;
  logic [N_CH-1:0][1:0]         speed_sel;
  logic [N_CH-1:0]              speed_out, alarm_out_n;
  logic [N_CH-1:0]              fwd, rev, stop_mode, alarm_reset, m0, m1, ch_locked, ch_alarm;
  logic [N_CH-1:0][RETRY_W-1:0] retry_cnt;
  logic [N_CH-1:0][SPD_W-1:0]   speed_cnt;

  int tests = 0;
  int fails = 0;
  int tb_cyc;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;
  exp_t exp_q[$];

  ble_motor_ctrl #(
    .N_CH(N_CH), .DEADTIME_CYC(4), .ALARM_HOLD_CYC(10), .RESET_PULSE_CYC(3),
    .MAX_RETRY(2), .SPD_WIN_CYC(WIN), .SPD_W(SPD_W)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .motor_state(motor_state), .motor_direction(motor_direction),
    .motor_alarm_reset(motor_alarm_reset), .speed_sel(speed_sel),
    .speed_out(speed_out), .alarm_out_n(alarm_out_n),
    .fwd(fwd), .rev(rev), .stop_mode(stop_mode), .alarm_reset(alarm_reset),
    .m0(m0), .m1(m1), .ch_locked(ch_locked), .ch_alarm(ch_alarm),
    .retry_cnt(retry_cnt), .speed_cnt(speed_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Bench-side cycle count since reset release, used to place window edges.
  always @(posedge sys_clk or negedge sys_rst)
    if (!sys_rst) tb_cyc <= 0;
    else          tb_cyc <= tb_cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input string t, input logic [31:0] v);
    exp_q.push_back('{t, v});
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL sb_empty: observed %0h, expected none queued", obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e.v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.v);
    end
  endtask

  function automatic logic [31:0] st0();
    return {26'd0, ch_locked[0], ch_alarm[0], alarm_reset[0], stop_mode[0], rev[0], fwd[0]};
  endfunction

  function automatic logic [31:0] ch1();
    return {26'd0, ch_locked[1], ch_alarm[1], alarm_reset[1], stop_mode[1], rev[1], fwd[1]};
  endfunction

  function automatic logic [31:0] all_ctrl();
    return {16'd0, fwd, rev, stop_mode, alarm_reset, m0, m1, ch_locked, ch_alarm};
  endfunction

  initial begin
    int base, end_w;
    motor_state = '0; motor_direction = '0; motor_alarm_reset = '0;
    speed_sel = '0; speed_out = '0; alarm_out_n = '1;

    // Reset state
    #12;
    push("rst_ctrl", 0);  chk(all_ctrl());
    push("rst_retry", 0); chk(32'(retry_cnt));
    push("rst_speed", 0); chk(speed_cnt);
    #10 sys_rst = 1'b1;
    tick(1);

    // Start channel 0 forward
    motor_state = 2'b01; motor_direction = 2'b01;
    speed_sel[0] = 2'b01; speed_sel[1] = 2'b10;
    push("run_pre", 0); tick(1); chk(st0());
    push("m_sel", 32'b1001); chk({m1, m0});
    push("run_fwd", C_FWD); tick(1); chk(st0());
    push("ch1_idle", 0); chk(ch1());

    // Reversal: 4 cycles dead-time then reverse
    motor_direction[0] = 1'b0;
    push("dt_pre", C_FWD); tick(1); chk(st0());
    for (int i = 0; i < 4; i++) begin
      push("dt_zero", 0); tick(1); chk(st0());
    end
    push("dt_rev", C_REV); tick(1); chk(st0());

    // Reversal with extra toggles inside the dead-time: timer not restarted
    motor_direction[0] = 1'b1;
    push("dt2_pre", C_REV); tick(1); chk(st0());
    motor_direction[0] = 1'b0;
    push("dt2_zero", 0); tick(1); chk(st0());
    motor_direction[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push("dt2_zero", 0); tick(1); chk(st0());
    end
    push("dt2_fwd", C_FWD); tick(1); chk(st0());

    // Persistent alarm: two auto-retries then lockout
    alarm_out_n[0] = 1'b0; motor_state[0] = 1'b0;
    push("al_stop", C_FWD); tick(1); chk(st0());
    push("al_sync", 0); tick(1); chk(st0());
    push("al_sync", 0); tick(1); chk(st0());
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) begin
        push("al_hold", C_ALM); tick(1); chk(st0());
      end
      push("al_retry", 32'(r + 1)); chk(32'(retry_cnt[0]));
      for (int i = 0; i < 3; i++) begin
        push("al_areset", C_ARST); tick(1); chk(st0());
      end
      push("al_idle", 0); tick(1); chk(st0());
    end
    for (int i = 0; i < 10; i++) begin
      push("al_hold3", C_ALM); tick(1); chk(st0());
    end
    push("lockout", C_LCK); tick(1); chk(st0());
    push("lock_retry", 2); chk(32'(retry_cnt[0]));

    // Manual reset out of lockout
    alarm_out_n[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push("lock_hold", C_LCK); tick(1); chk(st0());
    end
    motor_alarm_reset[0] = 1'b1;
    push("mr_pre", C_LCK); tick(1); chk(st0());
    push("mr_retry", 0); chk(32'(retry_cnt[0]));
    motor_alarm_reset[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push("mr_pulse", C_ARST); tick(1); chk(st0());
    end
    push("mr_idle", 0); tick(1); chk(st0());
    motor_state[0] = 1'b1; motor_direction[0] = 1'b1;
    push("rerun_pre", 0); tick(1); chk(st0());
    push("rerun", C_FWD); tick(1); chk(st0());

    // Manual reset held for two cycles: pulse lasts 3 cycles past release
    motor_alarm_reset[0] = 1'b1;
    push("mh_pre", C_FWD); tick(1); chk(st0());
    push("mh_hold", C_ARST); tick(1); chk(st0());
    motor_alarm_reset[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push("mh_pulse", C_ARST); tick(1); chk(st0());
    end
    push("mh_end", 0); tick(1); chk(st0());
    push("mh_run", C_FWD); tick(1); chk(st0());

    // Speed: 7 pulses in one window, last one counted on the window-end cycle
    base  = ((tb_cyc / WIN) + 1) * WIN;
    end_w = base + WIN;
    for (int j = 0; j < 7; j++) begin
      while (tb_cyc < end_w - 15 + 2 * j) tick(1);
      speed_out[0] = 1'b1;
      tick(1);
      speed_out[0] = 1'b0;
    end
    while (tb_cyc < end_w - 1) tick(1);
    push("spd_pre", 0); chk(speed_cnt[0]);
    tick(1);
    push("spd_7", 7);   chk(speed_cnt[0]);
    push("spd_ch1", 0); chk(speed_cnt[1]);
    while (tb_cyc < end_w + WIN) tick(1);
    push("spd_empty", 0); chk(speed_cnt[0]);

    // Async reset in the middle of an auto-retry pulse
    alarm_out_n[0] = 1'b0; motor_state[0] = 1'b0;
    tick(3);
    for (int i = 0; i < 10; i++) tick(1);
    push("ar2_retry", 1); chk(32'(retry_cnt[0]));
    push("ar2_pulse", C_ARST); tick(1); chk(st0());
    #3 sys_rst = 1'b0;
    #1;
    push("arst_ctrl", 0);  chk(all_ctrl());
    push("arst_retry", 0); chk(32'(retry_cnt));
    push("arst_speed", 0); chk(speed_cnt);
    alarm_out_n[0] = 1'b1;
    #1 sys_rst = 1'b1;
    tick(2);
    push("post_idle", 0);  chk(st0());
    push("post_retry", 0); chk(32'(retry_cnt[0]));
    tick(3);
    push("post_hold", 0);  chk(st0());

    if (exp_q.size() != 0) begin
      fails++;
      $error("FAIL sb_leftover: observed %0d queued, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
